// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128/192/256 encryption core, one round per accepted subkey
module aes_encrypt_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  output logic         ready,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  input  logic [127:0] subkey,
  input  logic         subkey_valid,
  output logic [3:0]   subkey_addr
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} fsm_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   addr_q, addr_d;
  logic         ready_q, ready_d;
  logic [127:0] sr_w;

  assign sr_w = shift_rows(sub_bytes(state_q));

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ct_d    = ct_q;
    nr_d    = nr_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    case (fsm_q)
      IDLE: begin
        if (start && key_len != 2'b00) begin
          state_d = plaintext;
          case (key_len)
            2'b01:   nr_d = 4'd10;
            2'b10:   nr_d = 4'd12;
            default: nr_d = 4'd14;
          endcase
          ready_d = 1'b0;
          addr_d  = 4'd0;
          fsm_d   = INIT;
        end
      end
      INIT: begin
        if (subkey_valid) begin
          state_d = state_q ^ subkey;
          addr_d  = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (subkey_valid) begin
          state_d = mix_columns(sr_w) ^ subkey;
          addr_d  = addr_q + 4'd1;
          if (addr_q == nr_q - 4'd1) fsm_d = FINAL;
        end
      end
      FINAL: begin
        if (subkey_valid) begin
          ct_d    = sr_w ^ subkey;
          ready_d = 1'b1;
          addr_d  = 4'd0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      ct_q    <= '0;
      nr_q    <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      nr_q    <= nr_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
    end
  end

  assign ready       = ready_q;
  assign ciphertext  = ct_q;
  assign subkey_addr = addr_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - directed FIPS-197 vectors for aes_encrypt_core
module tb_aes_encrypt_core;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic         ready;
  logic [127:0] plaintext = '0;
  logic [127:0] ciphertext;
  logic [127:0] subkey;
  logic         subkey_valid = 1'b0;
  logic [3:0]   subkey_addr;

  logic [127:0] rk [0:15];
  int tests = 0;
  int fails = 0;

  aes_encrypt_core dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_len      (key_len),
    .ready        (ready),
    .plaintext    (plaintext),
    .ciphertext   (ciphertext),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_addr  (subkey_addr)
  );

  always #5 clk = ~clk;

  assign subkey = rk[subkey_addr];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[31-8*i -: 8] = SBOX_T[2047 - 8*int'(w[31-8*i -: 8]) -: 8];
    return o;
  endfunction

  task automatic expand_key(input logic [1:0] kl, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nr;
    nk = (kl == 2'b01) ? 4 : (kl == 2'b10) ? 6 : 8;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Starts on the negedge after the caller's last sample, so a pending ready
  // makes every call a back-to-back start.
  task automatic run_block(input string tag, input logic [1:0] kl, input logic [255:0] key,
                           input logic [127:0] exp_ct, input int stall_pct, input bit scramble);
    int nr;
    int edges;
    int stalls;
    int consumed;
    int addr_errs;
    bit v;
    nr = (kl == 2'b01) ? 10 : (kl == 2'b10) ? 12 : 14;
    expand_key(kl, key);
    @(negedge clk);
    start = 1'b1;
    key_len = kl;
    plaintext = PT;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_ready_drop"}, {127'h0, ready}, 128'h0);
    if (scramble) begin
      plaintext = ~PT;
      key_len = (kl == 2'b01) ? 2'b11 : 2'b01;
    end
    edges = 0;
    stalls = 0;
    consumed = 0;
    addr_errs = 0;
    while (!ready && edges < 200) begin
      if (int'(subkey_addr) != consumed) addr_errs++;
      v = ($urandom_range(99) >= stall_pct);
      subkey_valid = v;
      start = scramble && (edges % 3 == 1);
      @(posedge clk);
      edges++;
      if (v) consumed++;
      else stalls++;
      #1;
    end
    start = 1'b0;
    check_eq({tag, "_ready"}, {127'h0, ready}, 128'h1);
    check_eq({tag, "_latency"}, 128'(edges), 128'(nr + 1 + stalls));
    check_eq({tag, "_consumed"}, 128'(consumed), 128'(nr + 1));
    check_eq({tag, "_addr_seq_errs"}, 128'(addr_errs), 128'h0);
    check_eq({tag, "_ct"}, ciphertext, exp_ct);
    check_eq({tag, "_addr_idle"}, {124'h0, subkey_addr}, 128'h0);
  endtask

  initial begin
    #12;
    check_eq("rst_ready", {127'h0, ready}, 128'h0);
    check_eq("rst_ct", ciphertext, 128'h0);
    check_eq("rst_addr", {124'h0, subkey_addr}, 128'h0);
    @(negedge clk);
    reset = 1'b1;

    run_block("aes128", 2'b01, KEY128, CT128, 0, 1'b0);
    run_block("aes192", 2'b10, KEY192, CT192, 0, 1'b0);
    run_block("aes256", 2'b11, KEY256, CT256, 0, 1'b0);
    run_block("stall128", 2'b01, KEY128, CT128, 50, 1'b0);
    run_block("scramble192", 2'b10, KEY192, CT192, 20, 1'b1);

    @(negedge clk);
    start = 1'b1;
    key_len = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("badlen_ready", {127'h0, ready}, 128'h1);
    check_eq("badlen_addr", {124'h0, subkey_addr}, 128'h0);
    check_eq("badlen_ct", ciphertext, CT192);
    run_block("after_badlen128", 2'b01, KEY128, CT128, 0, 1'b0);

    expand_key(2'b11, KEY256);
    @(negedge clk);
    start = 1'b1;
    key_len = 2'b11;
    plaintext = PT;
    subkey_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 30 && subkey_addr != 4'd5; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("midrst_round", {124'h0, subkey_addr}, 128'h5);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_ready", {127'h0, ready}, 128'h0);
    check_eq("midrst_ct", ciphertext, 128'h0);
    check_eq("midrst_addr", {124'h0, subkey_addr}, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    run_block("postrst128", 2'b01, KEY128, CT128, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
- Iterative AES encryption core: one round per accepted subkey, supports AES-128/192/256 per FIPS-197.
- Counterpart of the decrypt core, with the same command/subkey interface.
- Pulls round keys from the shared key-expansion store through subkey_addr/subkey_valid, counting up from round 0; the decrypt core counts down.
- Sits beside the decrypt core under the accelerator top level.

Parameters:
- none (state width fixed at 128; round count selected at run time by key_len)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  request to encrypt plaintext; sampled when idle
- key_len  input  2  01=AES-128 (Nr=10), 10=AES-192 (Nr=12), 11=AES-256 (Nr=14), 00=invalid
- ready  output  1  high once ciphertext is valid; held until next accepted start or reset
- plaintext  input  128  input block; byte 0 at [127:120], column-major state
- ciphertext  output  128  result block, same byte order
- subkey  input  128  round key for subkey_addr, same byte order
- subkey_valid  input  1  subkey corresponds to current subkey_addr and may be consumed this cycle
- subkey_addr  output  4  round-key index requested (0..Nr)

Behaviour:
- Reset (reset=0, async):
  - ready=0, ciphertext=0, subkey_addr=0.
  - Internal state register=0, round counter=0, FSM=IDLE.
  - Takes effect immediately, including mid-operation; no partial result is ever exposed.
- FSM states: IDLE, INIT, ROUND, FINAL.
- IDLE:
  - start=1 and key_len!=00 -> latch plaintext into state and Nr from key_len, ready<=0, subkey_addr<=0, go to INIT.
  - start with key_len=00 is ignored: no state change, ready unchanged.
- INIT, on subkey_valid:
  - state <= plaintext_latched XOR subkey.
  - subkey_addr<=1, go to ROUND.
- ROUND, on subkey_valid:
  - state <= MixColumns(ShiftRows(SubBytes(state))) XOR subkey.
  - subkey_addr += 1.
  - When subkey_addr==Nr-1 after this update... precisely: when the consumed address was Nr-1, go to FINAL with subkey_addr=Nr.
- FINAL, on subkey_valid:
  - ciphertext <= ShiftRows(SubBytes(state)) XOR subkey, with no MixColumns.
  - ready<=1, subkey_addr<=0, go to IDLE.
- subkey_valid=0 in INIT/ROUND/FINAL:
  - Stall; all registers hold, including subkey_addr.
  - No timeout.
- Held values during an operation:
  - start is ignored while not IDLE.
  - key_len and plaintext changes after acceptance have no effect (latched).
- Round accounting:
  - Exactly Nr+1 subkeys are consumed per block, addresses 0,1,...,Nr in strictly increasing order.
  - subkey_addr never exceeds Nr and never wraps.
- Timing:
  - ciphertext changes only on the FINAL transition; it holds its previous result during an operation.
  - Latency with subkey_valid held high: start accepted at cycle T -> ready=1 visible after cycle T+Nr+1 (11/13/15 edges after the start edge for 128/192/256).
- Back-to-back: start may be asserted in the same cycle ready is seen high. The block is accepted because the FSM is IDLE, and ready drops the next cycle.
- Arithmetic:
  - SubBytes uses the forward S-box, implemented combinationally (16 instances).
  - ShiftRows rotates row r left by r bytes.
  - MixColumns uses GF(2^8) with polynomial 0x11B; xtime = (b<<1) XOR (0x1B if b[7]).
  - All XOR is bitwise, 128 bits.

Test Plan:
1. AES-128: key 000102..0f (bench expands keys, subkey_valid always 1), plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises 11 edges after start; subkey_addr sequence 0..10.
2. AES-192: key 000102..17, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191; addresses 0..12. AES-256: key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089; addresses 0..14.
3. Stall: repeat test 1 with subkey_valid low on random cycles (~50%) -> same ciphertext; subkey_addr stable while valid low; latency = 11 + number of stalled cycles.
4. Protocol:
   - start with key_len=00 -> no ready change, subkey_addr stays 0.
   - start and changed plaintext/key_len mid-operation -> result still matches the first block.
   - back-to-back start on the ready cycle -> second block correct.
5. Reset mid-operation: assert reset=0 at round 5 of AES-256 -> ready=0, ciphertext=0, subkey_addr=0 immediately, before the next clock edge; a fresh AES-128 run afterwards gives the test 1 result.
